// File: rtl/uart_tx_sched.sv
// Purpose: round-robin scheduler sharing one UART transmitter among N_REQ byte streams; a frame is never interleaved.
// Latency: request seen in IDLE at cycle t gives data_valid/req_ready in t+1; uart_tx_done at d allows the next load at d+2.
// Backpressure: requesters hold req_valid until their req_ready pulse; no selection while busy is high or a byte is in flight.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   req_valid/req_data/req_last  per-requester byte offer (byte i at req_data[i*DATA_W +: DATA_W])
//   req_ready                one-cycle accept pulse, at most one bit set
//   p_data, data_valid       registered byte and one-cycle load strobe to the transmitter
//   busy, uart_tx_done       transmitter status and completion pulse
//   grant_id, active         current/last granted requester; scheduler not idle
//   err_timeout              one-cycle pulse when the transmitter never started
module uart_tx_sched #(
    parameter int  N_REQ         = 4,
    parameter int  DATA_W        = 8,
    parameter int  START_TIMEOUT = 4,
    localparam int ID_W          = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       p_data,
    output logic                    data_valid,
    input  logic                    busy,
    input  logic                    uart_tx_done,
    output logic [ID_W-1:0]         grant_id,
    output logic                    active,
    output logic                    err_timeout
);
    localparam int IDX_W = ID_W + 1;
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WAIT_START = 2'd1;
    localparam logic [1:0] S_WAIT_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              lock_q, lock_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] p_data_q, p_data_d;
    logic              data_valid_q, data_valid_d;
    logic [N_REQ-1:0]  req_ready_q, req_ready_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              active_q, active_d;
    logic              err_timeout_q, err_timeout_d;

    // Unpack the flat data bus so the winner's byte can be selected by index.
    logic [DATA_W-1:0] req_byte [N_REQ];
    for (genvar g = 0; g < N_REQ; g++) begin : g_byte
        assign req_byte[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Winner selection. While locked, grant_id_q is the lock owner and the
    // only eligible requester. Otherwise scan from rr_ptr upward; the loop runs
    // from the farthest offset down so the nearest valid requester is kept.
    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic [IDX_W-1:0] idx;

    always_comb begin
        win_found = 1'b0;
        win_id    = grant_id_q;
        idx       = '0;
        if (lock_q) begin
            win_found = req_valid[grant_id_q];
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                idx = {1'b0, rr_ptr_q} + IDX_W'(k);
                if (idx >= IDX_W'(N_REQ)) begin
                    idx = idx - IDX_W'(N_REQ);
                end
                if (req_valid[idx[ID_W-1:0]]) begin
                    win_found = 1'b1;
                    win_id    = idx[ID_W-1:0];
                end
            end
        end
    end

    // Pointer value that hands priority to the requester after the current one.
    logic [ID_W-1:0] rr_next;
    assign rr_next = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    // A completion pulse counts in either waiting state, including one that
    // arrives before busy was ever seen.
    logic tx_finish;
    assign tx_finish = uart_tx_done && ((state_q == S_WAIT_START) || (state_q == S_WAIT_DONE));

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        lock_d        = lock_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        p_data_d      = p_data_q;
        grant_id_d    = grant_id_q;
        data_valid_d  = 1'b0;
        req_ready_d   = '0;
        err_timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!busy && win_found) begin
                    p_data_d            = req_byte[win_id];
                    grant_id_d          = win_id;
                    last_d              = req_last[win_id];
                    data_valid_d        = 1'b1;
                    req_ready_d[win_id] = 1'b1;
                    // The data_valid cycle is the first counted WAIT_START cycle.
                    cnt_d               = CNT_W'(1);
                    state_d             = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                if (!uart_tx_done) begin
                    if (busy) begin
                        state_d = S_WAIT_DONE;
                    end else if (cnt_q == CNT_W'(START_TIMEOUT)) begin
                        err_timeout_d = 1'b1;
                        lock_d        = 1'b0;
                        rr_ptr_d      = rr_next;
                        state_d       = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT_DONE: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (tx_finish) begin
            state_d = S_IDLE;
            if (!last_q) begin
                // Mid-frame: keep the owner; rr_ptr resumes once the frame ends.
                lock_d = 1'b1;
            end else begin
                lock_d   = 1'b0;
                rr_ptr_d = rr_next;
            end
        end

        active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            lock_q        <= 1'b0;
            last_q        <= 1'b0;
            cnt_q         <= '0;
            p_data_q      <= '0;
            data_valid_q  <= 1'b0;
            req_ready_q   <= '0;
            grant_id_q    <= '0;
            active_q      <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            lock_q        <= lock_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            p_data_q      <= p_data_d;
            data_valid_q  <= data_valid_d;
            req_ready_q   <= req_ready_d;
            grant_id_q    <= grant_id_d;
            active_q      <= active_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign p_data      = p_data_q;
    assign data_valid  = data_valid_q;
    assign req_ready   = req_ready_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmitter among `N_REQ` byte-stream requesters. Each requester offers bytes with a valid/last handshake. The scheduler picks a winner and loads its byte into the transmitter's parallel input with a single-cycle `data_valid` strobe, then tracks `busy`/`uart_tx_done` to completion. A frame (bytes up to and including `req_last`) is never interleaved with another requester's bytes. It sits directly in front of the UART TX top and drives its `p_data`/`data_valid`.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: byte width; must match transmitter `p_data`.
- `START_TIMEOUT`, 4: cycles allowed after `data_valid` for the transmitter to raise `busy` or `uart_tx_done`.

- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input N_REQ: requester i offers a byte; held until its `req_ready` pulse.
- `req_data` input N_REQ*DATA_W: byte of requester i at bits [i*DATA_W +: DATA_W]; stable while `req_valid[i]`.
- `req_last` input N_REQ: offered byte ends the requester's frame.
- `req_ready` output N_REQ: one-cycle accept pulse; at most one bit high.
- `p_data` output DATA_W: registered byte to transmitter.
- `data_valid` output 1: one-cycle load strobe to transmitter.
- `busy` input 1: transmitter busy.
- `uart_tx_done` input 1: transmitter one-cycle completion pulse.
- `grant_id` output clog2(N_REQ): index of current/last granted requester.
- `active` output 1: scheduler not in IDLE.
- `err_timeout` output 1: one-cycle pulse on start timeout.

## Operation
- States: IDLE, WAIT_START, WAIT_DONE.
- **IDLE**
  - Arbitration runs only when `busy`=0.
  - Unlocked: the winner is the first i with `req_valid[i]`=1, searching `rr_ptr`, `rr_ptr`+1, … modulo N_REQ.
  - Locked: only the lock owner is eligible. Other requests are ignored even if the owner is idle, with no timeout.
  - On a winner: register `p_data`<=byte, `grant_id`<=i, and `last_q`<=`req_last[i]`. Assert `data_valid` and `req_ready[i]` for exactly the next cycle. Go to WAIT_START and clear the timeout counter.
- **WAIT_START**
  - `busy`=1: go to WAIT_DONE.
  - `uart_tx_done`=1 before `busy` is seen: treat as completion, same as WAIT_DONE.
  - Counter reaches `START_TIMEOUT` with neither seen: pulse `err_timeout`, clear the lock, set `rr_ptr`<=`grant_id`+1 mod N_REQ, go to IDLE.
- **WAIT_DONE**
  - On `uart_tx_done`, go to IDLE.
  - If `last_q`=0: lock to `grant_id`, leaving `rr_ptr` unchanged.
  - Otherwise: clear the lock and set `rr_ptr`<=`grant_id`+1 mod N_REQ.
- A requester whose `req_valid` is high but which is not granted keeps waiting. Data is never dropped.
- Fairness: when unlocked, every persistently-valid requester is granted within N_REQ frames.

## Timing
- Reset values (cycle after `rst` sampled high):
  - state IDLE, `rr_ptr`=0, unlocked, `last_q`=0.
  - `p_data`=0, `data_valid`=0, `req_ready`=0, `grant_id`=0, `active`=0, `err_timeout`=0.
- Reset mid-transfer abandons the frame and lock. The transmitter is reset by the same `rst`.
- Latency: a request seen in IDLE at cycle t (`busy`=0) gives `data_valid`/`req_ready` high in cycle t+1 only. The requester may change `req_data` from t+2.
- `active` is high in cycle t+1 through the cycle the FSM returns to IDLE. It equals (state != IDLE), registered.
- Minimum spacing between `data_valid` pulses: a `uart_tx_done` at cycle d permits a new selection at d+1 if `busy`=0, so the next `data_valid` comes at d+2.
- `uart_tx_done` outside WAIT_START/WAIT_DONE is ignored.
- `busy` and `uart_tx_done` high in the same WAIT_START cycle counts as completion.
- The timeout counter counts cycles in WAIT_START starting at 1 in the `data_valid` cycle. The timeout fires when the count equals `START_TIMEOUT` with no response.

## Test plan
- **Single byte.** Reset, then `req_valid[2]`=1, `req_data[2]`=8'hA5, `req_last[2]`=1. Model `busy` high 2 cycles after `data_valid` and `uart_tx_done` after 100 cycles.
  - One `data_valid` with `p_data`=8'hA5, `req_ready`=4'b0100, `grant_id`=2.
  - Afterwards `rr_ptr`=3.
- **Round-robin.** All four requesters valid with `req_last`=1 and bytes 8'h10..8'h13.
  - Transmitted order is 8'h10, 8'h11, 8'h12, 8'h13, then repeats 0,1,2,3 while still valid.
- **Frame lock.** Requester 1 sends 3 bytes with `req_last`=0,0,1 while requester 0 is continuously valid.
  - Requester 1's three bytes go back-to-back; requester 0 is granted only after the third.
- **Start timeout.** `START_TIMEOUT`=4; transmitter model never raises `busy`.
  - `err_timeout` pulses exactly once, 4 cycles after `data_valid`.
  - FSM returns to IDLE, the next requester is served, and the lock is cleared.
- **Reset mid-frame and busy gating.**
  - Assert `rst` during WAIT_DONE of a locked frame: all outputs return to reset values and `rr_ptr`=0.
  - Hold external `busy`=1 in IDLE with requests pending: no `data_valid` until `busy` falls.
